// File: rtl/src_write_cmd_pkg.sv
// Shared types and constants for the write-command executor.
package src_write_cmd_pkg;

    localparam int unsigned CMD_WIDTH      = 96;
    localparam int unsigned ADDR_MSB       = 95;
    localparam int unsigned ADDR_LSB       = 64;
    localparam int unsigned DATA_WIDTH     = 64;
    localparam int unsigned CMD_ADDR_WIDTH = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8;
    localparam int unsigned ALIGN_BITS     = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } write_cmd_t;

    // A command is executable only when its byte address is 64-bit aligned.
    function automatic logic is_aligned(input logic [CMD_ADDR_WIDTH-1:0] addr);
        return addr[ALIGN_BITS-1:0] == '0;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a written word becomes poppable one cycle after the write.
module cmd_fifo
    import src_write_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [CMD_WIDTH-1:0]        push_data,
    input  logic                        pop,
    output logic [CMD_WIDTH-1:0]        head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [CMD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_next;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = level - LVL_W'(1);
        end
    end

    // Full is held high in reset so the producer sees no space until the first edge.
    // Empty lags a push by one cycle but follows a pop immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            full  <= (level_next == LVL_W'(FIFO_DEPTH));
            empty <= pop ? (level_next == '0) : (level == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/src_write_cmd_exec.sv
// Executes buffered AXI-Stream write commands as single Avalon-MM 64-bit writes.
module src_write_cmd_exec
    import src_write_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CMD_WIDTH-1:0]  cmd_tdata,
    input  logic                  cmd_tvalid,
    output logic                  cmd_tready,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [DATA_WIDTH-1:0] avm_writedata,
    output logic [BE_WIDTH-1:0]   avm_byteenable,
    output logic                  avm_write,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic [31:0]           cmd_count,
    output logic [15:0]           err_count
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    state_t                  state_d;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [LVL_W-1:0]        fifo_level;
    logic [CMD_WIDTH-1:0]    head_bits;
    write_cmd_t              head_cmd;
    logic [ADDR_WIDTH-1:0]   avm_address_d;
    logic [DATA_WIDTH-1:0]   avm_writedata_d;
    logic                    avm_write_d;
    logic [31:0]             cmd_count_d;
    logic [15:0]             err_count_d;
    logic                    busy_d;

    assign fifo_push      = cmd_tvalid && cmd_tready;
    assign cmd_tready     = ~fifo_full;
    assign head_cmd       = write_cmd_t'(head_bits);
    assign avm_byteenable = '1;

    cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (cmd_tdata),
        .pop       (fifo_pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // An aligned head stays in the FIFO until its write completes, so it keeps its slot.
    always_comb begin
        state_d         = state;
        avm_address_d   = avm_address;
        avm_writedata_d = avm_writedata;
        avm_write_d     = avm_write;
        cmd_count_d     = cmd_count;
        err_count_d     = err_count;
        fifo_pop        = 1'b0;
        busy_d          = (fifo_level != '0) || (state == WRITE);

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (is_aligned(head_cmd.addr)) begin
                        avm_address_d   = ADDR_WIDTH'(head_cmd.addr);
                        avm_writedata_d = head_cmd.data;
                        avm_write_d     = 1'b1;
                        state_d         = WRITE;
                    end else begin
                        fifo_pop = 1'b1;
                        if (err_count != 16'hFFFF) begin
                            err_count_d = err_count + 16'd1;
                        end
                    end
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    avm_write_d = 1'b0;
                    fifo_pop    = 1'b1;
                    cmd_count_d = cmd_count + 32'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                avm_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
            cmd_count     <= '0;
            err_count     <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            avm_address   <= avm_address_d;
            avm_writedata <= avm_writedata_d;
            avm_write     <= avm_write_d;
            cmd_count     <= cmd_count_d;
            err_count     <= err_count_d;
            busy          <= busy_d;
        end
    end

endmodule
